// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcode constants, ALU control enums, the decoded
// bundle carried through the handshake registers, and immediate helpers.
package riscv_pkg;

    // Major opcodes (insn[6:0])
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // ALU operation; values match RV32I funct3 so OP/OP-IMM pass funct3 through
    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSll  = 3'b001,
        AluSlt  = 3'b010,
        AluSltu = 3'b011,
        AluXor  = 3'b100,
        AluSr   = 3'b101,
        AluOr   = 3'b110,
        AluAnd  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ASelRs1  = 2'd0,
        ASelPc   = 2'd1,
        ASelZero = 2'd2
    } a_sel_e;

    // Occupancy of output register + skid register
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        sign;
        logic        b_add_one;
        logic        b_negate;
        a_sel_e      a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } decoded_t;

    // ADDI x0, x0, 0
    localparam decoded_t NopBundle = '{
        alu_op:    AluAdd,
        sign:      1'b0,
        b_add_one: 1'b0,
        b_negate:  1'b0,
        a_sel:     ASelRs1,
        b_sel:     1'b1,
        imm:       32'h0,
        rd:        5'd0,
        rs1:       5'd0,
        rs2:       5'd0,
        illegal:   1'b0
    };

    function automatic logic [31:0] imm_i(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] insn);
        return {insn[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational RV32I instruction -> ALU control bundle decoder.
// Optional feature: define ALU_DECODE_ILLEGAL_EN to report unsupported encodings
// on the illegal flag; otherwise the flag stays 0. Either way they decode as NOP.
module insn_decode
    import riscv_pkg::*;
(
    input  logic [31:0] i_insn,
    output decoded_t    o_bundle
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_illegal;
    decoded_t   w_dec;

    assign w_opcode = i_insn[6:0];
    assign w_rd     = i_insn[11:7];
    assign w_funct3 = i_insn[14:12];
    assign w_rs1    = i_insn[19:15];
    assign w_rs2    = i_insn[24:20];
    assign w_funct7 = i_insn[31:25];

    // Map opcode/funct fields to ALU controls; unset fields stay zero
    always_comb begin
        w_dec     = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            OpcOp: begin
                w_dec.alu_op = alu_op_e'(w_funct3);
                w_dec.rd     = w_rd;
                w_dec.rs1    = w_rs1;
                w_dec.rs2    = w_rs2;
                if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000) begin
                        w_dec.b_negate  = 1'b1;
                        w_dec.b_add_one = 1'b1;
                    end else if (w_funct3 == 3'b101) begin
                        w_dec.sign = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (w_funct7 != 7'b0000000) begin
                    w_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                w_dec.alu_op = alu_op_e'(w_funct3);
                w_dec.b_sel  = 1'b1;
                w_dec.rd     = w_rd;
                w_dec.rs1    = w_rs1;
                w_dec.imm    = imm_i(i_insn);
                // Shifts take a 5-bit shamt; upper bits act as funct7
                if (w_funct3 == 3'b001) begin
                    w_dec.imm = {27'b0, w_rs2};
                    if (w_funct7 != 7'b0000000) w_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    w_dec.imm = {27'b0, w_rs2};
                    if (w_funct7 == 7'b0100000) begin
                        w_dec.sign = 1'b1;
                    end else if (w_funct7 != 7'b0000000) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            OpcLui: begin
                w_dec.a_sel = ASelZero;
                w_dec.b_sel = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.imm   = imm_u(i_insn);
            end
            OpcAuipc: begin
                w_dec.a_sel = ASelPc;
                w_dec.b_sel = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.imm   = imm_u(i_insn);
            end
            OpcJal: begin
                w_dec.a_sel = ASelPc;
                w_dec.b_sel = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.imm   = imm_j(i_insn);
            end
            OpcJalr: begin
                w_dec.b_sel = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.rs1   = w_rs1;
                w_dec.imm   = imm_i(i_insn);
                if (w_funct3 != 3'b000) w_illegal = 1'b1;
            end
            OpcLoad: begin
                w_dec.b_sel = 1'b1;
                w_dec.rd    = w_rd;
                w_dec.rs1   = w_rs1;
                w_dec.imm   = imm_i(i_insn);
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
                    w_illegal = 1'b1;
                end
            end
            OpcStore: begin
                w_dec.b_sel = 1'b1;
                w_dec.rs1   = w_rs1;
                w_dec.rs2   = w_rs2;
                w_dec.imm   = imm_s(i_insn);
                if (w_funct3 > 3'b010) w_illegal = 1'b1;
            end
            OpcBranch: begin
                w_dec.rs1 = w_rs1;
                w_dec.rs2 = w_rs2;
                w_dec.imm = imm_b(i_insn);
                // Equality compares via a - b; ordered compares via set-less-than
                case (w_funct3)
                    3'b000, 3'b001: begin
                        w_dec.b_negate  = 1'b1;
                        w_dec.b_add_one = 1'b1;
                    end
                    3'b100, 3'b101: w_dec.alu_op = AluSlt;
                    3'b110, 3'b111: w_dec.alu_op = AluSltu;
                    default:        w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) w_dec = NopBundle;
`ifdef ALU_DECODE_ILLEGAL_EN
        w_dec.illegal = w_illegal;
`else
        w_dec.illegal = 1'b0;
`endif
    end

    assign o_bundle = w_dec;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ALU control decoder stage: decodes RV32I instructions and buffers the result
// in an output register plus one skid register with valid/ready on both sides.
// Optional feature macro ALU_DECODE_ILLEGAL_EN is handled inside insn_decode.
module alu_ctrl_decoder
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_alu_op,
    output logic             out_sign,
    output logic             out_b_add_one,
    output logic             out_b_negate,
    output logic [1:0]       out_a_sel,
    output logic             out_b_sel,
    output logic [WIDTH-1:0] out_imm,
    output logic [WIDTH-1:0] out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_illegal
);

    skid_state_e      r_state;
    skid_state_e      w_state_next;
    decoded_t         w_dec;
    decoded_t         r_out;
    decoded_t         r_skid;
    logic [WIDTH-1:0] r_out_pc;
    logic [WIDTH-1:0] r_skid_pc;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_out_new;
    logic             w_load_out_skid;
    logic             w_load_skid;

    insn_decode u_insn_decode (
        .i_insn   (in_insn),
        .o_bundle (w_dec)
    );

    // Handshake flags come from registered state only, no input-to-output path
    assign in_ready   = (r_state != StTwo);
    assign out_valid  = (r_state != StEmpty);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy and register load enables; flush overrides any transfer
    always_comb begin
        w_state_next    = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            w_state_next = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_state_next   = StOne;
                        w_load_out_new = 1'b1;
                    end
                end
                StOne: begin
                    case ({w_in_fire, w_out_fire})
                        2'b10: begin
                            w_state_next = StTwo;
                            w_load_skid  = 1'b1;
                        end
                        2'b01: w_state_next = StEmpty;
                        2'b11: w_load_out_new = 1'b1;
                        default: ;
                    endcase
                end
                StTwo: begin
                    if (w_out_fire) begin
                        w_state_next    = StOne;
                        w_load_out_skid = 1'b1;
                    end
                end
                default: w_state_next = StEmpty;
            endcase
        end
    end

    // Output and skid bundle registers; skid always holds the younger entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_out_pc  <= '0;
            r_skid    <= '0;
            r_skid_pc <= '0;
        end else begin
            if (w_load_out_new) begin
                r_out    <= w_dec;
                r_out_pc <= in_pc;
            end else if (w_load_out_skid) begin
                r_out    <= r_skid;
                r_out_pc <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid    <= w_dec;
                r_skid_pc <= in_pc;
            end
        end
    end

    assign out_alu_op    = r_out.alu_op;
    assign out_sign      = r_out.sign;
    assign out_b_add_one = r_out.b_add_one;
    assign out_b_negate  = r_out.b_negate;
    assign out_a_sel     = r_out.a_sel;
    assign out_b_sel     = r_out.b_sel;
    assign out_imm       = WIDTH'($signed(r_out.imm));
    assign out_pc        = r_out_pc;
    assign out_rd        = r_out.rd;
    assign out_rs1       = r_out.rs1;
    assign out_rs2       = r_out.rs2;
    assign out_illegal   = r_out.illegal;

endmodule

// File: doc/alu_ctrl_decoder.md
ALU_CTRL_DECODER -- requirements
Module: alu_ctrl_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/PC/immediate width.
REQ-002 SHALL have clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have flush  input  1  discard all held instructions.
REQ-005 SHALL have in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have in_ready  output  1  decoder can accept.
REQ-007 SHALL have in_insn  input  32  RV32I instruction word.
REQ-008 SHALL have in_pc  input  WIDTH  instruction address.
REQ-009 SHALL have out_valid  output  1  decoded bundle valid.
REQ-010 SHALL have out_ready  input  1  execute stage accepts.
REQ-011 SHALL have out_alu_op  output  3  ALU operation code.
REQ-012 SHALL have out_sign, out_b_add_one, out_b_negate  output  1 each  ALU modifiers.
REQ-013 SHALL have out_a_sel  output  2  ALU a: 0 rs1, 1 pc, 2 zero.
REQ-014 SHALL have out_b_sel  output  1  ALU b: 0 rs2, 1 immediate.
REQ-015 SHALL have out_imm, out_pc  output  WIDTH each  sign-extended immediate; passed-through pc.
REQ-016 SHALL have out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-017 SHALL have out_illegal  output  1  unsupported encoding.

Function
REQ-018 SHALL transfer on in_valid&in_ready (input) and out_valid&out_ready (output); no transfer otherwise.
REQ-019 SHALL hold decoded bundles in an output register plus one skid register; states EMPTY, ONE, TWO.
REQ-020 SHALL transition: EMPTY+accept->ONE; ONE+accept-only->TWO; ONE+drain-only->EMPTY; ONE+both->ONE; TWO+drain->ONE (skid moves to output); all other cases hold state.
REQ-021 SHALL drive in_ready = (state != TWO) from registered state only; out_valid = (state != EMPTY).
REQ-022 SHALL present a bundle one cycle after acceptance when EMPTY; sustained throughput one per cycle; order preserved.
REQ-023 SHALL keep outputs stable while out_valid&!out_ready.
REQ-024 SHALL decode OP/OP-IMM: alu_op=funct3; b_negate=b_add_one=1 for SUB (OP, funct7[5]=1, funct3=000); sign=1 for SRA/SRAI (funct7[5]=1, funct3=101); shift imm = insn[24:20] zero-extended.
REQ-025 SHALL decode LUI (a_sel zero), AUIPC/JAL (a_sel pc), JALR/LOAD/STORE (a_sel rs1) as alu_op 000, b_sel 1, U/J/I/S immediate.
REQ-026 SHALL decode BRANCH with b_sel 0: BEQ/BNE op 000 negate+add_one 1; BLT/BGE op 010; BLTU/BGEU op 011; B immediate.
REQ-027 SHALL force flags to 0 and op 000 for any field not set above.
REQ-028 SHALL, on flush, go to EMPTY next edge, ignore a same-cycle input transfer, and set in_ready the following cycle.

Reset
REQ-029 SHALL on rst_n low immediately enter EMPTY: out_valid 0, in_ready 1, all data outputs 0.
REQ-030 SHALL discard held bundles when reset asserts mid-operation; first accept possible on first edge after release.

Configuration
REQ-031 SHALL, with ALU_DECODE_ILLEGAL_EN defined, set out_illegal 1 for unknown opcodes and invalid funct3/funct7 combinations, other fields as NOP (ADDI x0,x0,0).
REQ-032 SHALL, without ALU_DECODE_ILLEGAL_EN, tie out_illegal 0 and decode unknown encodings as NOP.

Structure
REQ-033 SHALL place opcode constants, alu_op enum, a_sel enum and decoded-bundle struct in package riscv_pkg.
REQ-034 SHALL use one combinational sub-module, insn_decode (instruction -> bundle); handshake/skid logic in the top.

Verification
REQ-035 SHALL check ADD x3,x1,x2 (0x002081B3) -> op 000, negate 0, add_one 0, rd 3, rs1 1, rs2 2, b_sel 0, one-cycle latency.
REQ-036 SHALL check SUB 0x402081B3 -> negate 1, add_one 1; SRAI 0x40335293 -> op 101, sign 1, imm 3, rd 5, rs1 6.
REQ-037 SHALL check BLT x1,x2,+8 (0x0020C463) -> op 010, b_sel 0, imm 8.
REQ-038 SHALL check out_ready low 3 cycles with 3 back-to-back inputs -> in_ready 0 after two accepted, third held, all delivered in order.
REQ-039 SHALL check flush in state TWO with in_valid 1 -> out_valid 0 next cycle, no bundle delivered.
REQ-040 SHALL check opcode 0x7F with macro defined -> out_illegal 1; undefined -> out_illegal 0, NOP.
